// File: rtl/wm_pkg.sv
// Shared definitions for the water level monitor and MainController:
// supervision state encoding, default thresholds and a saturating helper.
package wm_pkg;

    localparam int DEF_LEVEL_W        = 10;
    localparam int DEF_EMPTY_THRESH   = 16;
    localparam int DEF_OVERFLOW_LEVEL = 1000;
    localparam int DEF_HYST           = 8;
    localparam int DEF_FILL_TIMEOUT   = 50;
    localparam int DEF_DRAIN_TIMEOUT  = 30;

    typedef enum logic [1:0] {
        MON_IDLE     = 2'd0,
        MON_FILLING  = 2'd1,
        MON_DRAINING = 2'd2,
        MON_FAULT    = 2'd3
    } monitor_state_t;

    // Lower edge of a hysteresis band, clamped so small targets never wrap.
    function automatic int sat_floor(input int value, input int band);
        return (value > band) ? (value - band) : 0;
    endfunction

endpackage

// File: rtl/level_avg4.sv
// Four-tap moving average of the raw level sensor with a running sum,
// plus a valid flag once the tap line has been filled after reset.
module level_avg4
    import wm_pkg::*;
#(
    parameter int LEVEL_W = DEF_LEVEL_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] sample,
    output logic [LEVEL_W-1:0] level_filtered,
    output logic               level_valid
);

    localparam int SUM_W = LEVEL_W + 2;

    logic [LEVEL_W-1:0] taps [4];
    logic [SUM_W-1:0]   sum;
    logic [SUM_W-1:0]   sum_next;
    logic [1:0]         sample_count;

    // The oldest tap leaves the sum as the new sample enters, so the sum never needs a full re-add.
    assign sum_next = sum + SUM_W'(sample) - SUM_W'(taps[3]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                taps[i] <= '0;
            end
            sum            <= '0;
            level_filtered <= '0;
            level_valid    <= 1'b0;
            sample_count   <= '0;
        end else begin
            taps[0] <= sample;
            for (int i = 1; i < 4; i++) begin
                taps[i] <= taps[i-1];
            end
            sum            <= sum_next;
            level_filtered <= sum_next[SUM_W-1:2];
            if (!level_valid) begin
                sample_count <= sample_count + 2'd1;
                level_valid  <= (sample_count == 2'd3);
            end
        end
    end

endmodule

// File: rtl/water_level_monitor.sv
// Sensor conditioning and command supervision ahead of MainController:
// filtered level, hysteretic level flags and sticky fill/drain timeout errors.
module water_level_monitor
    import wm_pkg::*;
#(
    parameter int LEVEL_W        = DEF_LEVEL_W,
    parameter int EMPTY_THRESH   = DEF_EMPTY_THRESH,
    parameter int OVERFLOW_LEVEL = DEF_OVERFLOW_LEVEL,
    parameter int HYST           = DEF_HYST,
    parameter int FILL_TIMEOUT   = DEF_FILL_TIMEOUT,
    parameter int DRAIN_TIMEOUT  = DEF_DRAIN_TIMEOUT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] water_level_sensor,
    input  logic [LEVEL_W-1:0] target_level,
    input  logic               water_valve,
    input  logic               drain_pump,
    input  logic               error_clear,
    output logic [LEVEL_W-1:0] level_filtered,
    output logic               level_valid,
    output logic               target_reached,
    output logic               water_empty,
    output logic               overflow,
    output logic               water_flow_error,
    output logic               drainage_error
);

    localparam int CNT_W = $clog2((FILL_TIMEOUT > DRAIN_TIMEOUT) ? FILL_TIMEOUT : DRAIN_TIMEOUT);

    localparam logic [CNT_W-1:0]   FILL_LAST   = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [LEVEL_W-1:0] EMPTY_SET   = LEVEL_W'(EMPTY_THRESH);
    localparam logic [LEVEL_W-1:0] EMPTY_CLEAR = LEVEL_W'(EMPTY_THRESH + HYST);
    localparam logic [LEVEL_W-1:0] OVF_LEVEL   = LEVEL_W'(OVERFLOW_LEVEL);

    monitor_state_t     state;
    logic [CNT_W-1:0]   cycle_count;
    logic               pump_d;
    logic [LEVEL_W-1:0] target_floor;

    assign target_floor = LEVEL_W'(sat_floor(int'(target_level), HYST));

    level_avg4 #(
        .LEVEL_W(LEVEL_W)
    ) u_avg (
        .clk           (clk),
        .reset         (reset),
        .sample        (water_level_sensor),
        .level_filtered(level_filtered),
        .level_valid   (level_valid)
    );

    // Level flags hold inside their hysteresis bands; a fresh overflow sample beats error_clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_reached <= 1'b0;
            water_empty    <= 1'b1;
            overflow       <= 1'b0;
        end else if (!level_valid) begin
            target_reached <= 1'b0;
            water_empty    <= 1'b1;
            overflow       <= 1'b0;
        end else begin
            if (level_filtered >= target_level) begin
                target_reached <= 1'b1;
            end else if (level_filtered < target_floor) begin
                target_reached <= 1'b0;
            end

            if (level_filtered <= EMPTY_SET) begin
                water_empty <= 1'b1;
            end else if (level_filtered > EMPTY_CLEAR) begin
                water_empty <= 1'b0;
            end

            if (level_filtered >= OVF_LEVEL) begin
                overflow <= 1'b1;
            end else if (error_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    // Supervision: completion is checked before the timeout so a success on the last allowed cycle is not a fault.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= MON_IDLE;
            cycle_count      <= '0;
            pump_d           <= 1'b0;
            water_flow_error <= 1'b0;
            drainage_error   <= 1'b0;
        end else begin
            pump_d <= drain_pump;
            case (state)
                MON_IDLE: begin
                    cycle_count <= '0;
                    if (drain_pump) begin
                        state <= MON_DRAINING;
                    end else if (water_valve) begin
                        state <= MON_FILLING;
                    end
                end
                MON_FILLING: begin
                    if (target_reached || !water_valve) begin
                        state       <= MON_IDLE;
                        cycle_count <= '0;
                    end else if (cycle_count == FILL_LAST) begin
                        state            <= MON_FAULT;
                        cycle_count      <= '0;
                        water_flow_error <= 1'b1;
                    end else if (drain_pump && !pump_d) begin
                        state       <= MON_DRAINING;
                        cycle_count <= '0;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                MON_DRAINING: begin
                    if (water_empty || !drain_pump) begin
                        state       <= MON_IDLE;
                        cycle_count <= '0;
                    end else if (cycle_count == DRAIN_LAST) begin
                        state          <= MON_FAULT;
                        cycle_count    <= '0;
                        drainage_error <= 1'b1;
                    end else begin
                        cycle_count <= cycle_count + 1'b1;
                    end
                end
                MON_FAULT: begin
                    cycle_count <= '0;
                    if (error_clear) begin
                        state            <= MON_IDLE;
                        water_flow_error <= 1'b0;
                        drainage_error   <= 1'b0;
                    end
                end
                default: begin
                    state       <= MON_IDLE;
                    cycle_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_water_level_monitor.sv
// Bench for water_level_monitor: a reset/step vector table, hand-written
// multi-cycle corner sequences and a randomized run against a behavioural model.
module tb_water_level_monitor;
    import wm_pkg::*;

    localparam int FILL_TO  = 50;
    localparam int DRAIN_TO = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] sensor;
    logic [9:0] target;
    logic       valve;
    logic       pump;
    logic       clr;
    logic [9:0] level_filtered;
    logic       level_valid;
    logic       target_reached;
    logic       water_empty;
    logic       overflow;
    logic       water_flow_error;
    logic       drainage_error;

    int total = 0;
    int bad   = 0;

    water_level_monitor dut (
        .clk               (clk),
        .reset             (reset),
        .water_level_sensor(sensor),
        .target_level      (target),
        .water_valve       (valve),
        .drain_pump        (pump),
        .error_clear       (clr),
        .level_filtered    (level_filtered),
        .level_valid       (level_valid),
        .target_reached    (target_reached),
        .water_empty       (water_empty),
        .overflow          (overflow),
        .water_flow_error  (water_flow_error),
        .drainage_error    (drainage_error)
    );

    always #5 clk = ~clk;

    // Behavioural model: sample history, elapsed time since entering a mode, flag rules.
    localparam int M_IDLE = 0, M_FILL = 1, M_DRAIN = 2, M_FAULT = 3;
    int m_hist[$];
    int m_samples, m_filt, m_mode, m_entry, m_cycle;
    bit m_valid, m_tr, m_we, m_ov, m_wfe, m_dre, m_pump_prev;

    task automatic model_reset();
        m_hist.delete();
        m_samples = 0; m_filt = 0; m_mode = M_IDLE; m_entry = 0; m_cycle = 0;
        m_valid = 0; m_tr = 0; m_we = 1; m_ov = 0; m_wfe = 0; m_dre = 0; m_pump_prev = 0;
    endtask

    task automatic model_enter(input int mode);
        m_mode  = mode;
        m_entry = m_cycle;
    endtask

    task automatic model_step();
        int elapsed, floor_lvl, acc;
        bit tr, we, ov;
        m_cycle++;
        elapsed = m_cycle - m_entry;
        case (m_mode)
            M_IDLE: begin
                if (pump) model_enter(M_DRAIN);
                else if (valve) model_enter(M_FILL);
            end
            M_FILL: begin
                if (m_tr || !valve) model_enter(M_IDLE);
                else if (elapsed == FILL_TO) begin model_enter(M_FAULT); m_wfe = 1; end
                else if (pump && !m_pump_prev) model_enter(M_DRAIN);
            end
            M_DRAIN: begin
                if (m_we || !pump) model_enter(M_IDLE);
                else if (elapsed == DRAIN_TO) begin model_enter(M_FAULT); m_dre = 1; end
            end
            default: begin
                if (clr) begin model_enter(M_IDLE); m_wfe = 0; m_dre = 0; end
            end
        endcase
        tr = m_tr; we = m_we; ov = m_ov;
        if (!m_valid) begin
            tr = 0; we = 1; ov = 0;
        end else begin
            floor_lvl = (int'(target) > 8) ? int'(target) - 8 : 0;
            if (m_filt >= int'(target)) tr = 1;
            else if (m_filt < floor_lvl) tr = 0;
            if (m_filt <= 16) we = 1;
            else if (m_filt > 24) we = 0;
            ov = (m_ov && !clr) || (m_filt >= 1000);
        end
        m_tr = tr; m_we = we; m_ov = ov;
        m_pump_prev = pump;
        m_hist.push_front(int'(sensor));
        if (m_hist.size() > 4) void'(m_hist.pop_back());
        m_samples++;
        acc = 0;
        foreach (m_hist[k]) acc += m_hist[k];
        m_filt  = acc / 4;
        m_valid = (m_samples >= 4);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [9:0] s, input logic v, input logic p, input logic c);
        sensor = s; valve = v; pump = p; clr = c;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sensor = '0; target = 10'd300; valve = 0; pump = 0; clr = 0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [9:0] sensor;
        logic [9:0] filt;
        logic       valid;
        logic       tr;
        logic       we;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        int base, s;
        logic [15:0] act, exp_v;

        vecs[0] = '{10'd400, 10'd100, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{10'd400, 10'd200, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{10'd400, 10'd300, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{10'd400, 10'd400, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{10'd400, 10'd400, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{10'd0,   10'd300, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{10'd0,   10'd200, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{10'd0,   10'd100, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{10'd0,   10'd0,   1'b1, 1'b0, 1'b0};
        vecs[9] = '{10'd0,   10'd0,   1'b1, 1'b0, 1'b1};

        // Reset values and the 0->400 step response
        do_reset();
        #1;
        check_output("rst_outputs", {level_filtered, level_valid, target_reached, water_empty,
                     overflow, water_flow_error, drainage_error}, 16'b0000000000_0_0_1_0_0_0);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i].sensor, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("step%0d_filt", i), level_filtered, vecs[i].filt);
            check_output($sformatf("step%0d_valid", i), level_valid, vecs[i].valid);
            check_output($sformatf("step%0d_tr", i), target_reached, vecs[i].tr);
            check_output($sformatf("step%0d_we", i), water_empty, vecs[i].we);
        end

        // Fill to target, then hysteresis at 295 / 291
        do_reset();
        repeat (4) apply_stimulus(10'd280, 1'b1, 1'b0, 1'b0);
        check_output("fill_state", dut.state, MON_FILLING);
        apply_stimulus(10'd320, 1'b1, 1'b0, 1'b0);
        apply_stimulus(10'd320, 1'b1, 1'b0, 1'b0);
        check_output("fill_filt300", level_filtered, 10'd300);
        check_output("fill_tr_lag", target_reached, 1'b0);
        apply_stimulus(10'd320, 1'b1, 1'b0, 1'b0);
        check_output("fill_tr_set", target_reached, 1'b1);
        apply_stimulus(10'd320, 1'b1, 1'b0, 1'b0);
        check_output("fill_to_idle", dut.state, MON_IDLE);
        repeat (4) apply_stimulus(10'd295, 1'b0, 1'b0, 1'b0);
        check_output("hyst_295", target_reached, 1'b1);
        repeat (4) apply_stimulus(10'd291, 1'b0, 1'b0, 1'b0);
        check_output("hyst_filt291", level_filtered, 10'd291);
        check_output("hyst_292_hold", target_reached, 1'b1);
        apply_stimulus(10'd291, 1'b0, 1'b0, 1'b0);
        check_output("hyst_291_clear", target_reached, 1'b0);

        // Fill timeout with a stuck sensor, then error_clear
        do_reset();
        n = 0;
        while (n < 100 && !water_flow_error) begin
            apply_stimulus(10'd0, 1'b1, 1'b0, 1'b0);
            n++;
        end
        check_output("fill_timeout_edges", n, FILL_TO + 1);
        repeat (3) apply_stimulus(10'd0, 1'b0, 1'b1, 1'b0);
        check_output("fault_holds", {dut.state, water_flow_error}, {MON_FAULT, 1'b1});
        apply_stimulus(10'd0, 1'b0, 1'b0, 1'b1);
        check_output("fault_clear", {dut.state, water_flow_error}, {MON_IDLE, 1'b0});

        // Drain to empty in time, then drain timeout
        do_reset();
        repeat (6) apply_stimulus(10'd300, 1'b0, 1'b0, 1'b0);
        n = 0;
        do begin
            apply_stimulus(10'd10, 1'b0, 1'b1, 1'b0);
            n++;
        end while (n < 20 && dut.state != MON_IDLE);
        check_output("drain_ok_edges", n, 6);
        check_output("drain_ok_flags", {water_empty, drainage_error}, 2'b10);
        do_reset();
        repeat (6) apply_stimulus(10'd300, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (n < 100 && !drainage_error) begin
            apply_stimulus(10'd300, 1'b0, 1'b1, 1'b0);
            n++;
        end
        check_output("drain_timeout_edges", n, DRAIN_TO + 1);
        apply_stimulus(10'd300, 1'b0, 1'b0, 1'b1);
        check_output("drain_clear", drainage_error, 1'b0);

        // Both commands at once, then sticky overflow
        do_reset();
        repeat (6) apply_stimulus(10'd500, 1'b0, 1'b0, 1'b0);
        apply_stimulus(10'd500, 1'b1, 1'b1, 1'b0);
        check_output("both_cmd_drain", dut.state, MON_DRAINING);
        apply_stimulus(10'd500, 1'b0, 1'b0, 1'b0);
        repeat (4) apply_stimulus(10'd1010, 1'b0, 1'b0, 1'b0);
        check_output("ovf_lag", overflow, 1'b0);
        apply_stimulus(10'd1010, 1'b0, 1'b0, 1'b0);
        check_output("ovf_set", overflow, 1'b1);
        repeat (6) apply_stimulus(10'd500, 1'b0, 1'b0, 1'b0);
        check_output("ovf_sticky", overflow, 1'b1);
        apply_stimulus(10'd500, 1'b0, 1'b0, 1'b1);
        check_output("ovf_clear", overflow, 1'b0);

        // Asynchronous reset mid-fill and restart of the counter
        do_reset();
        repeat (26) apply_stimulus(10'd0, 1'b1, 1'b0, 1'b0);
        check_output("midfill_count", dut.cycle_count, 25);
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_output("async_rst_outputs", {level_filtered, level_valid, target_reached, water_empty,
                     overflow, water_flow_error, drainage_error}, 16'b0000000000_0_0_1_0_0_0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(10'd0, 1'b1, 1'b0, 1'b0);
        check_output("restart_count0", {dut.state, dut.cycle_count}, {MON_FILLING, 6'd0});
        repeat (3) apply_stimulus(10'd0, 1'b1, 1'b0, 1'b0);
        check_output("restart_count3", dut.cycle_count, 3);

        // Randomized run against the model
        do_reset();
        base = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            if (i % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0: base = int'($urandom_range(0, 30));
                    1: base = int'($urandom_range(250, 350));
                    2: base = int'($urandom_range(990, 1023));
                    default: base = int'($urandom_range(0, 1023));
                endcase
                target = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 10))
                                                     : 10'($urandom_range(0, 1023));
            end
            s = base + int'($urandom_range(0, 6)) - 3;
            if (s < 0) s = 0;
            if (s > 1023) s = 1023;
            sensor = 10'(s);
            if ($urandom_range(0, 39) == 0) valve = ~valve;
            if ($urandom_range(0, 47) == 0) pump = ~pump;
            clr = ($urandom_range(0, 19) == 0);
            tick();
            act   = {level_filtered, level_valid, target_reached, water_empty,
                     overflow, water_flow_error, drainage_error};
            exp_v = {10'(m_filt), m_valid, m_tr, m_we, m_ov, m_wfe, m_dre};
            check_output($sformatf("random_cycle%0d", i), act, exp_v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
